mul_div_seq: RTL and testbench
==============================

// Module: mul_div_seq
// PURPOSE
// Iteration sequencer for multiply and divide inside the arithmetic unit control path.
// On a start pulse from the arithmetic control it emits one micro-pulse per cycle to the AU:
//   - multiply: shift-add over A:C;
//   - divide: non-restoring over A:C.
// It then returns done, plus an overflow pulse when the divide cannot proceed.
// Sign handling, operand loading and result moves stay in the arithmetic control.
// PARAMETERS
// STEPS  30  iterations per operation (magnitude bits per word)
// CNT_W  5   step counter width; must satisfy 2**CNT_W > STEPS
// PORTS
// clk                      in   1  system clock
// resetn                   in   1  asynchronous active-low reset
// start_mul_from_ctrl      in   1  pulse: begin multiply (A=0, B=multiplicand, C=multiplier)
// start_div_from_ctrl      in   1  pulse: begin divide (A=dividend, B=divisor, C=0)
// abort_from_pu            in   1  pulse: panel stop, abandon the operation
// reg_c_lsb_from_au        in   1  level: C[0]; reflects all AU pulses of the previous cycle
// reg_a_sign_from_au       in   1  level: A sign; 1 = negative; same timing as C[0]
// do_sum_to_au             out  1  pulse: A <= A + B
// do_sub_to_au             out  1  pulse: A <= A - B
// do_right_shift_ac_to_au  out  1  pulse: A:C >>= 1
// do_left_shift_ac_to_au   out  1  pulse: A:C <<= 1, C[0] <= 0
// do_set_c0_to_au          out  1  pulse: C[0] <= 1
// busy_to_ctrl             out  1  level: high in every state except IDLE
// done_to_ctrl             out  1  pulse: operation complete
// div_overflow_to_ctrl     out  1  pulse: coincides with done; |dividend| >= |divisor|
// BEHAVIOUR
// - Reset value: all outputs 0, state IDLE, cnt 0, ovf 0, qsgn 0.
// - All outputs decode combinationally from the registered state, cnt and captured flags.
// - Each output is high for exactly one cycle per issue.
// - States and transitions:
//   - IDLE:
//     - start_mul -> M_ADD, cnt=0.
//     - Else start_div -> D_SUB.
//     - If both are high the same cycle, multiply wins and start_div is dropped.
//   - M_ADD: do_sum iff reg_c_lsb_from_au=1; -> M_SHIFT.
//   - M_SHIFT: do_right_shift_ac; cnt++; if cnt==STEPS-1 -> DONE, else -> M_ADD.
//   - D_SUB: do_sub; -> D_CHK.
//   - D_CHK:
//     - reg_a_sign_from_au=0 -> DONE with ovf=1 (no further AU pulses).
//     - Else -> D_SHIFT, cnt=0.
//   - D_SHIFT: capture qsgn=reg_a_sign_from_au; do_left_shift_ac; -> D_ALU.
//   - D_ALU:
//     - qsgn=0: do_set_c0 and do_sub in the same cycle.
//     - qsgn=1: do_sum.
//     - cnt++; if cnt==STEPS-1 -> DONE, else -> D_SHIFT.
//   - DONE: done_to_ctrl=1; div_overflow_to_ctrl=ovf; clear ovf; -> IDLE.
// - Latency, counting start-pulse cycle t as 0:
//   - multiply: done at t+2*STEPS+1.
//   - divide: done at t+2*STEPS+3.
//   - divide overflow: done at t+3.
// - Starts arriving while busy are ignored; they are not queued.
// - abort_from_pu in any non-IDLE state:
//   - next state is IDLE;
//   - the current cycle's decoded pulse still issues;
//   - no done, no overflow pulse;
//   - ovf cleared.
// - abort_from_pu in IDLE has no effect.
// - abort_from_pu outranks a same-cycle start.
// - The counter never wraps: it is reset on every entry to M_ADD or D_SHIFT from IDLE/D_CHK.
// - No remainder correction is done; the final remainder may be negative. The control handles it.
// - Asynchronous reset mid-operation: immediate IDLE, every output low; a partial AU result is abandoned.
// TESTING
// - Multiply, STEPS=30, C model=5, start at t=0:
//   -> do_sum at t=1 and t=5 only; do_right_shift_ac on t=2,4,..,60;
//   -> done at t=61; busy t=1..61.
// - Divide, A model=+3/8, B=+3/4 (fractions), start at t=0:
//   -> do_sub t=1; left shifts t=3,5,..,61;
//   -> C holds 0.1000...0b; done t=63; no overflow.
// - Divide overflow, A=B=+1/2:
//   -> do_sub t=1; a_sign=0 at t=2;
//   -> done and div_overflow_to_ctrl both at t=3; no shift pulses.
// - Abort at t=10 during multiply:
//   -> last AU pulse at t=10; busy low from t=11; no done.
//   -> A new start_div at t=12 is accepted (do_sub at t=13).
// - start_mul and start_div same cycle -> multiply sequence only.
//   - start_div at t=20 of that multiply -> ignored; only one done.
// - resetn low at t=30 of a divide -> all outputs 0 asynchronously.
//   - After release, idle until the next start; no spurious done.

Source files
------------

// File: rtl/mul_div_seq.sv
// Iteration sequencer for the arithmetic unit's multiply and divide.
// Multiply runs shift-add over A:C. Divide runs non-restoring division over A:C.
// Each state decodes to one set of single-cycle micro-pulses to the AU.
// Sign handling, operand loading and remainder correction are left to the arithmetic control.
module mul_div_seq #(
    parameter int STEPS = 30,
    parameter int CNT_W = 5
) (
    input  logic clk,
    input  logic resetn,
    input  logic start_mul_from_ctrl,
    input  logic start_div_from_ctrl,
    input  logic abort_from_pu,
    input  logic reg_c_lsb_from_au,
    input  logic reg_a_sign_from_au,
    output logic do_sum_to_au,
    output logic do_sub_to_au,
    output logic do_right_shift_ac_to_au,
    output logic do_left_shift_ac_to_au,
    output logic do_set_c0_to_au,
    output logic busy_to_ctrl,
    output logic done_to_ctrl,
    output logic div_overflow_to_ctrl
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_M_ADD   = 3'd1;
    localparam logic [2:0] S_M_SHIFT = 3'd2;
    localparam logic [2:0] S_D_SUB   = 3'd3;
    localparam logic [2:0] S_D_CHK   = 3'd4;
    localparam logic [2:0] S_D_SHIFT = 3'd5;
    localparam logic [2:0] S_D_ALU   = 3'd6;
    localparam logic [2:0] S_DONE    = 3'd7;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEPS - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             qsgn_q, qsgn_d;

    // Next-state logic: sequencing, step count, overflow flag, quotient-sign capture, abort override
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        qsgn_d  = qsgn_q;
        case (state_q)
            S_IDLE: begin
                // An abort arriving with a start suppresses the start
                if (abort_from_pu) begin
                    state_d = S_IDLE;
                end else if (start_mul_from_ctrl) begin
                    state_d = S_M_ADD;
                    cnt_d   = '0;
                end else if (start_div_from_ctrl) begin
                    state_d = S_D_SUB;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_M_ADD: state_d = S_M_SHIFT;
            S_M_SHIFT: begin
                cnt_d = cnt_q + CNT_ONE;
                if (cnt_q == CNT_LAST) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_M_ADD;
                end
            end
            S_D_SUB: state_d = S_D_CHK;
            S_D_CHK: begin
                // A non-negative trial remainder means |dividend| >= |divisor|
                if (!reg_a_sign_from_au) begin
                    state_d = S_DONE;
                    ovf_d   = 1'b1;
                end else begin
                    state_d = S_D_SHIFT;
                    cnt_d   = '0;
                end
            end
            S_D_SHIFT: begin
                // Sign of the remainder before this shift selects the next add/sub
                qsgn_d  = reg_a_sign_from_au;
                state_d = S_D_ALU;
            end
            S_D_ALU: begin
                cnt_d = cnt_q + CNT_ONE;
                if (cnt_q == CNT_LAST) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_D_SHIFT;
                end
            end
            S_DONE: begin
                ovf_d   = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (abort_from_pu && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            ovf_d   = 1'b0;
        end else begin
            ovf_d = ovf_d;
        end
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            qsgn_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            qsgn_q  <= qsgn_d;
        end
    end

    // Output decode from the registered state and captured flags
    always_comb begin
        do_sum_to_au            = 1'b0;
        do_sub_to_au            = 1'b0;
        do_right_shift_ac_to_au = 1'b0;
        do_left_shift_ac_to_au  = 1'b0;
        do_set_c0_to_au         = 1'b0;
        done_to_ctrl            = 1'b0;
        div_overflow_to_ctrl    = 1'b0;
        busy_to_ctrl            = (state_q != S_IDLE);
        case (state_q)
            S_M_ADD:   do_sum_to_au = reg_c_lsb_from_au;
            S_M_SHIFT: do_right_shift_ac_to_au = 1'b1;
            S_D_SUB:   do_sub_to_au = 1'b1;
            S_D_SHIFT: do_left_shift_ac_to_au = 1'b1;
            S_D_ALU: begin
                if (qsgn_q) begin
                    do_sum_to_au = 1'b1;
                end else begin
                    do_sub_to_au    = 1'b1;
                    do_set_c0_to_au = 1'b1;
                end
            end
            S_DONE: begin
                done_to_ctrl         = 1'b1;
                div_overflow_to_ctrl = ovf_q;
            end
            default: busy_to_ctrl = (state_q != S_IDLE);
        endcase
    end

endmodule

// File: tb/tb_mul_div_seq.sv
// Directed bench for mul_div_seq.
// A small behavioural AU (A, B and C registers) answers the sequencer's pulses,
// so the C[0] and A-sign feedback come from real arithmetic.
// Every cycle's outputs are compared against hand-derived pulse schedules.
module tb_mul_div_seq;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic start_mul = 1'b0, start_div = 1'b0, abort_pu = 1'b0;
    logic c_lsb, a_sign;
    logic do_sum, do_sub, do_rsh, do_lsh, do_set, busy, done, ovf;

    logic               ld_en = 1'b0;
    logic signed [63:0] ld_a = 64'sd0, ld_b = 64'sd0;
    logic        [63:0] ld_c = 64'd0;
    logic signed [63:0] au_a, au_b;
    logic        [63:0] au_c;

    int n_cmp = 0;
    int n_err = 0;

    mul_div_seq #(.STEPS(30), .CNT_W(5)) dut (
        .clk                     (clk),
        .resetn                  (resetn),
        .start_mul_from_ctrl     (start_mul),
        .start_div_from_ctrl     (start_div),
        .abort_from_pu           (abort_pu),
        .reg_c_lsb_from_au       (c_lsb),
        .reg_a_sign_from_au      (a_sign),
        .do_sum_to_au            (do_sum),
        .do_sub_to_au            (do_sub),
        .do_right_shift_ac_to_au (do_rsh),
        .do_left_shift_ac_to_au  (do_lsh),
        .do_set_c0_to_au         (do_set),
        .busy_to_ctrl            (busy),
        .done_to_ctrl            (done),
        .div_overflow_to_ctrl    (ovf)
    );

    always #5 clk = ~clk;

    assign c_lsb  = au_c[0];
    assign a_sign = au_a[63];

    // Behavioural AU: A and C hold 30 magnitude bits; A is kept as a wide signed value
    always_ff @(posedge clk) begin
        if (ld_en) begin
            au_a <= ld_a;
            au_b <= ld_b;
            au_c <= ld_c;
        end else begin
            if (do_sum) au_a <= au_a + au_b;
            if (do_sub) au_a <= au_a - au_b;
            if (do_set) au_c <= au_c | 64'd1;
            if (do_rsh) begin
                au_a <= au_a >>> 1;
                au_c <= (au_c >> 1) | ({63'd0, au_a[0]} << 29);
            end
            if (do_lsh) begin
                au_a <= (au_a <<< 1) | {63'd0, au_c[29]};
                au_c <= (au_c << 1) & 64'h0000_0000_3FFF_FFFF;
            end
        end
    end

    // Expected output vector {sum, sub, rsh, lsh, set, busy, done, ovf} for test id at cycle t
    function automatic logic [7:0] exp_vec(input int id, input int t);
        logic s, sb, r, l, st, b, d, o;
        s = 1'b0; sb = 1'b0; r = 1'b0; l = 1'b0; st = 1'b0; b = 1'b0; d = 1'b0; o = 1'b0;
        if (id == 1 || id == 6 || (id == 4 && t <= 10)) begin
            b = (t >= 1 && t <= 61);
            s = (t == 1 || t == 5);
            r = (t >= 2 && t <= 60 && (t % 2) == 0);
            d = (t == 61);
        end else if (id == 2 || (id == 7 && t < 30)) begin
            b  = (t >= 1 && t <= 63);
            sb = (t == 1 || t == 6);
            st = (t == 6);
            l  = (t >= 3 && t <= 61 && (t % 2) == 1);
            s  = (t >= 4 && t <= 62 && (t % 2) == 0 && t != 6);
            d  = (t == 63);
        end else if (id == 3) begin
            b  = (t >= 1 && t <= 3);
            sb = (t == 1);
            d  = (t == 3);
            o  = (t == 3);
        end else if (id == 4) begin
            b  = (t == 13 || t == 14);
            sb = (t == 13);
        end else begin
            b = 1'b0;
        end
        return {s, sb, r, l, st, b, d, o};
    endfunction

    // Drive the stimulus for test id at cycle t
    task automatic drive(input int id, input int t);
        start_mul = 1'b0; start_div = 1'b0; abort_pu = 1'b0; ld_en = 1'b0;
        if (t == 0 && (id == 1 || id == 4 || id == 5 || id == 6)) begin
            ld_en = 1'b1; ld_a = 64'sd0; ld_b = 64'sd7; ld_c = 64'd5;
            start_mul = 1'b1;
            start_div = (id == 6);
            abort_pu  = (id == 5);
        end
        if (t == 0 && (id == 2 || id == 7)) begin
            ld_en = 1'b1; ld_a = 64'sd3 <<< 27; ld_b = 64'sd3 <<< 28; ld_c = 64'd0;
            start_div = 1'b1;
        end
        if (t == 0 && id == 3) begin
            ld_en = 1'b1; ld_a = 64'sd1 <<< 29; ld_b = 64'sd1 <<< 29; ld_c = 64'd0;
            start_div = 1'b1;
        end
        if (id == 4 && t == 10) abort_pu = 1'b1;
        if (id == 4 && t == 12) begin
            ld_en = 1'b1; ld_a = 64'sd3 <<< 27; ld_b = 64'sd3 <<< 28; ld_c = 64'd0;
            start_div = 1'b1;
        end
        if (id == 4 && t == 14) abort_pu = 1'b1;
        if (id == 5 && t == 2) abort_pu = 1'b1;
        if (id == 6 && t == 20) start_div = 1'b1;
        if (id == 7) resetn = (t >= 30 && t <= 32) ? 1'b0 : 1'b1;
    endtask

    // Run one directed sequence of n cycles, comparing every cycle
    task automatic run_seq(input int id, input string tag, input int n);
        logic [7:0] obs, exp;
        for (int t = 0; t < n; t++) begin
            drive(id, t);
            #1;
            obs = {do_sum, do_sub, do_rsh, do_lsh, do_set, busy, done, ovf};
            exp = exp_vec(id, t);
            n_cmp++;
            assert (obs === exp) else begin
                n_err++;
                $error("FAIL %s t=%0d observed=%b expected=%b (sum,sub,rsh,lsh,set,busy,done,ovf)",
                       tag, t, obs, exp);
            end
            @(negedge clk);
        end
        drive(0, 1);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        logic [7:0] obs;
        repeat (2) @(negedge clk);
        #1;
        obs = {do_sum, do_sub, do_rsh, do_lsh, do_set, busy, done, ovf};
        n_cmp++;
        assert (obs === 8'd0) else begin
            n_err++;
            $error("FAIL reset_state observed=%b expected=%b", obs, 8'd0);
        end
        @(negedge clk);
        resetn = 1'b1;
        repeat (2) @(negedge clk);

        run_seq(1, "multiply_c5", 64);
        run_seq(2, "divide_3_8_by_3_4", 66);
        run_seq(3, "divide_overflow", 6);
        run_seq(4, "abort_then_div", 17);
        run_seq(5, "abort_in_idle", 4);
        run_seq(6, "dual_start_busy_start", 64);
        run_seq(7, "reset_mid_divide", 42);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
